// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: variable frame length, selectable bit order.
// Latency: first bit on dout the cycle after accept, then one bit per en cycle.
// Backpressure: din_ready only in IDLE or on the consumed last bit (back-to-back frames).
module piso_serializer #(
  parameter int unsigned N          = 32,
  parameter logic        IDLE_LEVEL = 1'b0,
  localparam int unsigned LEN_W     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     din,
  input  logic [LEN_W-1:0] len,
  input  logic             msb_first,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

  localparam logic [LEN_W-1:0] N_L   = LEN_W'(N);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             msb_q, msb_d;

  logic [LEN_W-1:0] len_eff;
  logic [N-1:0]     load_val;
  logic             last_bit;
  logic             accept;

  // Clamp the requested length and align the incoming word so the first bit sits at the output end.
  always_comb begin
    len_eff = len;
    if ((len == '0) || (len > N_L)) begin
      len_eff = N_L;
    end
    if (msb_first) begin
      load_val = din << (N_L - len_eff);
    end else begin
      // Shift of an N-bit mask by N yields zero, so a full-width frame keeps every bit.
      load_val = din & ~({N{1'b1}} << len_eff);
    end
  end

  assign last_bit  = (state_q == SHIFT) && (rem_q == ONE_L);
  assign din_ready = (state_q == IDLE) || (last_bit && en);
  assign accept    = din_valid && din_ready;

  // Next-state and datapath update: a new frame wins over the shift of the last bit.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    msb_d   = msb_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_val;
      rem_d   = len_eff;
      msb_d   = msb_first;
    end else if ((state_q == SHIFT) && en) begin
      shreg_d = msb_q ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
      rem_d   = rem_q - ONE_L;
      if (last_bit) begin
        state_d = IDLE;
      end
    end
  end

  // State register with synchronous reset that abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      msb_q   <= msb_d;
    end
  end

  // Serial-side outputs decode registered state only.
  assign dout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign dout_last  = last_bit;
  assign dout       = (state_q == SHIFT) ? (msb_q ? shreg_q[N-1] : shreg_q[0]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer with N=8: queue-of-bits reference plus directed frames.
// Outputs are compared every cycle at the falling edge; inputs change 1 time unit after the rising edge.
// Observed consumed bits are accumulated so each scenario can be pinned to literal sequences.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic [3:0] len = 4'd0;
  logic       msb_first = 1'b0;
  logic       din_valid = 1'b0;
  logic       en = 1'b0;
  logic       din_ready, dout, dout_valid, dout_last, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit b;
    bit last;
  } mbit_t;
  mbit_t mq[$];
  bit    chk_en = 1'b0;

  logic [31:0] cap_bits = 32'd0;
  int          cap_n = 0;
  int          cap_last = 0;
  int          cap_vcyc = 0;

  piso_serializer #(.N(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .len(len), .msb_first(msb_first),
    .din_valid(din_valid), .din_ready(din_ready), .en(en), .dout(dout),
    .dout_valid(dout_valid), .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lastbits(input int k);
    return int'(cap_bits & ((32'd1 << k) - 32'd1));
  endfunction

  // Reference: a frame is a list of bits in send order; the head is what dout must show.
  initial begin
    bit    e_v, e_d, e_l, e_r, acc;
    int    flen;
    mbit_t m;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_v = (mq.size() > 0);
        e_d = e_v ? mq[0].b : 1'b0;
        e_l = e_v && mq[0].last;
        e_r = !e_v || (en && mq[0].last);
        check1("dout_valid", dout_valid, e_v);
        check1("dout", dout, e_d);
        check1("dout_last", dout_last, e_l);
        check1("busy", busy, e_v);
        check1("din_ready", din_ready, e_r);
        if (dout_valid) cap_vcyc++;
        if (dout_valid && en) begin
          cap_bits = {cap_bits[30:0], dout};
          cap_n++;
          if (dout_last) cap_last++;
        end
        if (reset) begin
          mq.delete();
        end else begin
          acc = din_valid && e_r;
          if (e_v && en) void'(mq.pop_front());
          if (acc) begin
            flen = ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
            for (int i = 0; i < flen; i++) begin
              m.b    = msb_first ? din[flen-1-i] : din[i];
              m.last = (i == flen - 1);
              mq.push_back(m);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents a frame and returns just after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic [3:0] l, input logic m);
    bit acc;
    int t;
    din = d; len = l; msb_first = m; din_valid = 1'b1;
    acc = 1'b0; t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = din_ready;
      tick();
      t++;
    end
    din_valid = 1'b0;
    if (!acc) checkn("send_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int  n0, l0, v0;
    bit  acc;
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check1("rst_din_ready", din_ready, 1'b1);
    check1("rst_dout_valid", dout_valid, 1'b0);
    check1("rst_dout", dout, 1'b0);

    // 1: A5, 8 bits, MSB first
    en = 1'b1;
    n0 = cap_n; l0 = cap_last;
    send(8'hA5, 4'd8, 1'b1);
    wait_cycles(10);
    checkn("t1_count", cap_n - n0, 8);
    checkn("t1_bits", lastbits(8), 'hA5);
    checkn("t1_lasts", cap_last - l0, 1);
    check1("t1_idle_busy", busy, 1'b0);
    check1("t1_idle_dout", dout, 1'b0);

    // 2: A5, 4 bits, LSB first -> 1,0,1,0
    n0 = cap_n; l0 = cap_last;
    send(8'hA5, 4'd4, 1'b0);
    wait_cycles(6);
    checkn("t2_count", cap_n - n0, 4);
    checkn("t2_bits", lastbits(4), 'hA);
    checkn("t2_lasts", cap_last - l0, 1);

    // 3: F0, len 0 (full), en alternating starting low on the first bit
    n0 = cap_n; v0 = cap_vcyc;
    din = 8'hF0; len = 4'd0; msb_first = 1'b1; din_valid = 1'b1; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = din_valid && din_ready;
      tick();
      if (acc) din_valid = 1'b0;
      en = ~en;
    end
    din_valid = 1'b0;
    en = 1'b1;
    wait_cycles(2);
    checkn("t3_count", cap_n - n0, 8);
    checkn("t3_bits", lastbits(8), 'hF0);
    checkn("t3_valid_cycles", cap_vcyc - v0, 16);

    // 4: back-to-back 81 MSB-first then 03 len 2 LSB-first, no gap
    n0 = cap_n; l0 = cap_last; v0 = cap_vcyc;
    send(8'h81, 4'd8, 1'b1);
    send(8'h03, 4'd2, 1'b0);
    wait_cycles(4);
    checkn("t4_count", cap_n - n0, 10);
    checkn("t4_bits", lastbits(10), 'h207);
    checkn("t4_lasts", cap_last - l0, 2);
    checkn("t4_valid_cycles", cap_vcyc - v0, 10);

    // 5: reset during bit 3, then 55 MSB-first
    l0 = cap_last;
    send(8'hC3, 4'd8, 1'b1);
    wait_cycles(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("t5_after_rst_valid", dout_valid, 1'b0);
    check1("t5_after_rst_ready", din_ready, 1'b1);
    checkn("t5_no_last", cap_last - l0, 0);
    n0 = cap_n; l0 = cap_last;
    send(8'h55, 4'd8, 1'b1);
    wait_cycles(10);
    checkn("t5_count", cap_n - n0, 8);
    checkn("t5_bits", lastbits(8), 'h55);
    checkn("t5_lasts", cap_last - l0, 1);

    // 6: a pulse while busy is ignored; len 12 clamps to 8
    n0 = cap_n; l0 = cap_last;
    send(8'h3C, 4'd8, 1'b1);
    tick();
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 8'h3C;
    wait_cycles(10);
    checkn("t6_count", cap_n - n0, 8);
    checkn("t6_bits", lastbits(8), 'h3C);
    checkn("t6_lasts", cap_last - l0, 1);
    n0 = cap_n; l0 = cap_last;
    send(8'hFF, 4'd12, 1'b0);
    wait_cycles(10);
    checkn("t6_clamp_count", cap_n - n0, 8);
    checkn("t6_clamp_bits", lastbits(8), 'hFF);
    checkn("t6_clamp_lasts", cap_last - l0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
